// File: rtl/stage_pkg.sv
// Shared types, widths and LFSR helpers for the StageData game sequencer.
package stage_pkg;

    localparam int unsigned SYM_W   = 2;
    localparam int unsigned LFSR_W  = 8;
    localparam int unsigned TIMER_W = 8;
    localparam int unsigned STAGE_W = 6;

    // Feedback taps: bits 7, 5, 4 and 3.
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 8'b1011_1000;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_PLAY_ON,
        ST_PLAY_GAP,
        ST_WAIT_IN,
        ST_WIN,
        ST_FAIL
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

    // Low symbol bits of lfsr_step(v), without forming the full stepped word.
    function automatic logic [SYM_W-1:0] lfsr_next_symbol(input logic [LFSR_W-1:0] v);
        return {v[0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/stage_lfsr.sv
// 8-bit Fibonacci LFSR with synchronous load-to-seed and advance enables.
module stage_lfsr
    import stage_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    output logic [LFSR_W-1:0] value_d
);

    logic [LFSR_W-1:0] value_q;

    // value_d is the register content after the coming edge; load wins over advance.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = SEED;
        end else if (advance) begin
            value_d = lfsr_step(value_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= SEED;
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Game-level controller for the StageData 2-bit symbol path ("repeat-after-me").
// Define STAGE_TIMEOUT_EN to fail a stage when the player stays idle in WAIT_IN.
module stage_sequencer
    import stage_pkg::*;
#(
    parameter int unsigned       MAX_STAGE      = 16,
    parameter int unsigned       HOLD_CYCLES    = 4,
    parameter int unsigned       GAP_CYCLES     = 2,
    parameter logic [LFSR_W-1:0] SEED           = DEFAULT_SEED,
    parameter int unsigned       TIMEOUT_CYCLES = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       user_valid,
    input  logic [1:0] user_data,
    output logic       stageon,
    output logic [1:0] stage_data,
    output logic       play_valid,
    output logic [1:0] play_data,
    output logic [5:0] stage_num,
    output logic       busy,
    output logic       win,
    output logic       fail
);

    localparam int unsigned IDX_W = $clog2(MAX_STAGE);
    localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
`ifdef STAGE_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(TIMEOUT_CYCLES - 1);
`else
    localparam logic [TIMER_W-1:0] WAIT_LOAD = '0;
`endif

    if (MAX_STAGE < 2 || MAX_STAGE > 32) begin : g_bad_max_stage
        $error("stage_sequencer: MAX_STAGE must be within 2..32");
    end
    if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_timing
        $error("stage_sequencer: HOLD_CYCLES, GAP_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("stage_sequencer: SEED must be nonzero");
    end

    state_t               state_q, state_d;
    logic [STAGE_W-1:0]   stage_num_q, stage_num_d;
    logic [STAGE_W-1:0]   idx_q, idx_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [SYM_W-1:0]     seq_q [MAX_STAGE];
    logic [SYM_W-1:0]     seq_d [MAX_STAGE];

    logic                 lfsr_load, lfsr_adv;
    logic [LFSR_W-1:0]    lfsr_d;

    logic                 stageon_q, stageon_d;
    logic [SYM_W-1:0]     stage_data_q, stage_data_d;
    logic                 play_valid_q, play_valid_d;
    logic [SYM_W-1:0]     play_data_q, play_data_d;
    logic                 busy_q, busy_d;
    logic                 win_q, win_d;
    logic                 fail_q, fail_d;

    stage_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk     (clock),
        .rst_n   (reset),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .value_d (lfsr_d)
    );

    always_comb begin
        state_d     = state_q;
        stage_num_d = stage_num_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        seq_d       = seq_q;
        lfsr_load   = 1'b0;
        lfsr_adv    = 1'b0;

        case (state_q)
            ST_IDLE, ST_WIN, ST_FAIL: begin
                if (start) begin
                    state_d     = ST_ADD;
                    stage_num_d = '0;
                    idx_d       = '0;
                    timer_d     = '0;
                    lfsr_load   = 1'b1;
                    for (int unsigned i = 0; i < MAX_STAGE; i++) begin
                        seq_d[i] = '0;
                    end
                end
            end

            // stage_data_q already holds the symbol the LFSR produces in this cycle.
            ST_ADD: begin
                lfsr_adv                          = 1'b1;
                seq_d[stage_num_q[IDX_W-1:0]]     = stage_data_q;
                idx_d                             = '0;
                timer_d                           = HOLD_LOAD;
                state_d                           = ST_PLAY_ON;
            end

            ST_PLAY_ON: begin
                if (timer_q == '0) begin
                    timer_d = GAP_LOAD;
                    state_d = ST_PLAY_GAP;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            ST_PLAY_GAP: begin
                if (timer_q == '0) begin
                    if (idx_q == stage_num_q) begin
                        idx_d   = '0;
                        timer_d = WAIT_LOAD;
                        state_d = ST_WAIT_IN;
                    end else begin
                        idx_d   = idx_q + STAGE_W'(1);
                        timer_d = HOLD_LOAD;
                        state_d = ST_PLAY_ON;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end

            ST_WAIT_IN: begin
                if (user_valid) begin
                    if (user_data != seq_q[idx_q[IDX_W-1:0]]) begin
                        state_d = ST_FAIL;
                    end else if (idx_q == stage_num_q) begin
                        stage_num_d = stage_num_q + STAGE_W'(1);
                        state_d     = (stage_num_d == STAGE_W'(MAX_STAGE)) ? ST_WIN : ST_ADD;
                    end else begin
                        idx_d   = idx_q + STAGE_W'(1);
                        timer_d = WAIT_LOAD;
                    end
                end
`ifdef STAGE_TIMEOUT_EN
                else if (timer_q == '0) begin
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with state_q.
    always_comb begin
        stageon_d    = (state_d == ST_ADD);
        stage_data_d = stageon_d ? lfsr_next_symbol(lfsr_d) : '0;
        play_valid_d = (state_d == ST_PLAY_ON);
        play_data_d  = play_valid_d ? seq_d[idx_d[IDX_W-1:0]] : '0;
        busy_d       = (state_d == ST_ADD) || (state_d == ST_PLAY_ON) ||
                       (state_d == ST_PLAY_GAP) || (state_d == ST_WAIT_IN);
        win_d        = (state_d == ST_WIN);
        fail_d       = (state_d == ST_FAIL);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            stage_num_q  <= '0;
            idx_q        <= '0;
            timer_q      <= '0;
            for (int unsigned i = 0; i < MAX_STAGE; i++) begin
                seq_q[i] <= '0;
            end
            stageon_q    <= 1'b0;
            stage_data_q <= '0;
            play_valid_q <= 1'b0;
            play_data_q  <= '0;
            busy_q       <= 1'b0;
            win_q        <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stage_num_q  <= stage_num_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            seq_q        <= seq_d;
            stageon_q    <= stageon_d;
            stage_data_q <= stage_data_d;
            play_valid_q <= play_valid_d;
            play_data_q  <= play_data_d;
            busy_q       <= busy_d;
            win_q        <= win_d;
            fail_q       <= fail_d;
        end
    end

    assign stageon    = stageon_q;
    assign stage_data = stage_data_q;
    assign play_valid = play_valid_q;
    assign play_data  = play_data_q;
    assign stage_num  = stage_num_q;
    assign busy       = busy_q;
    assign win        = win_q;
    assign fail       = fail_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized self-checking bench for stage_sequencer against a queue-based game model.
module tb_stage_sequencer;

    localparam int unsigned MAXS = 4;
    localparam int unsigned HOLD = 4;
    localparam int unsigned GAP  = 2;
    localparam logic [7:0]  SEED = 8'hA5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       user_valid = 1'b0;
    logic [1:0] user_data = 2'b00;
    logic       stageon;
    logic [1:0] stage_data;
    logic       play_valid;
    logic [1:0] play_data;
    logic [5:0] stage_num;
    logic       busy, win, fail;

    int checks   = 0;
    int failures = 0;

    // Game model: symbol list, completed stage count, outcome of the last game.
    logic [7:0] m_lfsr;
    logic [1:0] m_seq[$];
    int         m_stage;
    bit         m_won;

    stage_sequencer #(
        .MAX_STAGE   (MAXS),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP),
        .SEED        (SEED)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .user_valid (user_valid),
        .user_data  (user_data),
        .stageon    (stageon),
        .stage_data (stage_data),
        .play_valid (play_valid),
        .play_data  (play_data),
        .stage_num  (stage_num),
        .busy       (busy),
        .win        (win),
        .fail       (fail)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Packed order: stageon, stage_data, play_valid, play_data, busy, win, fail, stage_num.
    task automatic expect_out(input string tag, input logic so, input logic [1:0] sd,
                              input logic pv, input logic [1:0] pd, input logic bz,
                              input logic w, input logic f, input int sn);
        logic [5:0] sn6;
        sn6 = 6'(sn);
        check_eq(tag, {stageon, stage_data, play_valid, play_data, busy, win, fail, stage_num},
                      {so, sd, pv, pd, bz, w, f, sn6});
    endtask

    function automatic logic [7:0] m_step(input logic [7:0] v);
        logic fb;
        fb = v[7] ^ v[5] ^ v[4] ^ v[3];
        return {v[6:0], fb};
    endfunction

    task automatic model_new_game();
        m_lfsr  = SEED;
        m_seq.delete();
        m_stage = 0;
    endtask

    task automatic model_add();
        m_lfsr = m_step(m_lfsr);
        m_seq.push_back(m_lfsr[1:0]);
    endtask

    task automatic stray();
        user_valid = ($urandom_range(0, 3) == 0);
        user_data  = 2'($urandom_range(0, 3));
        start      = ($urandom_range(0, 7) == 0);
    endtask

    // Called at the negedge of a start edge: next sample is the ADD cycle.
    task automatic do_start();
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(negedge clock);
    endtask

    // Entered at the negedge of an ADD cycle; leaves at the first WAIT_IN negedge.
    task automatic run_stage();
        model_add();
        expect_out("add", 1'b1, m_seq[m_seq.size()-1], 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, m_stage);
        stray();
        for (int k = 0; k < m_seq.size(); k++) begin
            for (int h = 0; h < int'(HOLD); h++) begin
                @(negedge clock);
                expect_out("play_on", 1'b0, 2'b00, 1'b1, m_seq[k], 1'b1, 1'b0, 1'b0, m_stage);
                stray();
            end
            for (int g = 0; g < int'(GAP); g++) begin
                @(negedge clock);
                expect_out("play_gap", 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, m_stage);
                stray();
            end
        end
        @(negedge clock);
        user_valid = 1'b0;
        start      = 1'b0;
        expect_out("wait_in", 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, m_stage);
    endtask

    task automatic answer(input int bad_pos, input logic [1:0] mask, output bit ended);
        int         n;
        logic [1:0] sym;
        ended = 1'b0;
        n     = m_seq.size();
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clock);
                expect_out("wait_idle", 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, m_stage);
            end
            sym = m_seq[k];
            if (k == bad_pos) sym = sym ^ mask;
            user_valid = 1'b1;
            user_data  = sym;
            @(posedge clock);
            #1 user_valid = 1'b0;
            @(negedge clock);
            if (k == bad_pos) begin
                m_won = 1'b0;
                expect_out("fail_entry", 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, m_stage);
                ended = 1'b1;
                return;
            end
            if (k < n - 1)
                expect_out("wait_next", 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, m_stage);
        end
        m_stage++;
        if (m_stage == int'(MAXS)) begin
            m_won = 1'b1;
            expect_out("win", 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, m_stage);
            ended = 1'b1;
        end
    endtask

    task automatic poke_after_end();
        repeat (3) begin
            user_valid = 1'b1;
            user_data  = 2'($urandom_range(0, 3));
            @(negedge clock);
            expect_out("hold_end", 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, m_won, !m_won, m_stage);
        end
        user_valid = 1'b0;
    endtask

    task automatic play_game(input int err_pct);
        bit ended;
        int bad;
        do_start();
        model_new_game();
        ended = 1'b0;
        while (!ended) begin
            run_stage();
            bad = ($urandom_range(0, 99) < err_pct) ? int'($urandom_range(0, m_seq.size() - 1)) : -1;
            answer(bad, 2'($urandom_range(1, 3)), ended);
        end
        poke_after_end();
    endtask

    initial begin
        bit ended;

        #1 reset = 1'b0;
        #20;
        expect_out("reset", 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        expect_out("idle", 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 0);

        // Known sequence from the default seed: 10, 01, 10; then a wrong second entry.
        do_start();
        model_new_game();
        check_eq("sym0_const", stage_data, 2'b10);
        run_stage();
        answer(-1, 2'b00, ended);
        check_eq("sym1_const", stage_data, 2'b01);
        run_stage();
        answer(1, 2'b10, ended);
        check_eq("fail_flag", fail, 1'b1);
        check_eq("fail_stage_const", stage_num, 6'd1);
        poke_after_end();

        // Fresh game replays the same symbols and runs to a win.
        do_start();
        model_new_game();
        check_eq("restart_sym_const", stage_data, 2'b10);
        ended = 1'b0;
        while (!ended) begin
            run_stage();
            if (m_stage == 2) check_eq("sym2_const", m_seq[2], 2'b10);
            answer(-1, 2'b00, ended);
        end
        check_eq("win_stage_const", stage_num, 6'(MAXS));
        poke_after_end();

        // Asynchronous reset in the middle of playback.
        do_start();
        model_new_game();
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b0;
        #1 expect_out("reset_mid", 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        expect_out("idle_after_rst", 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 0);
        do_start();
        model_new_game();
        check_eq("post_rst_sym_const", stage_data, 2'b10);
        run_stage();
        answer(-1, 2'b00, ended);

        // Let the interrupted game finish, then random games.
        while (!ended) begin
            run_stage();
            answer(-1, 2'b00, ended);
        end
        poke_after_end();
        repeat (30) play_game(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
